cpu_nios_ram_arbiter: RTL
=========================

// Module: cpu_nios_ram_arbiter
// PURPOSE
//  Two-master Avalon-MM arbiter that shares the single-port on-chip RAM (32-bit, 32768 words).
//  It sits between the Nios data master (m0) and the alarm/DMA engine (m1) and drives the RAM's
//  address, byteenable, chipselect, write, writedata and clken. Arbitration is round-robin.
//  Reads have fixed latency and are pipelined; writes complete in the accept cycle.
// PARAMETERS
//  ADDR_W     15  word-address width (RAM depth = 2**ADDR_W)
//  DATA_W     32  data width; byteenable width = DATA_W/8
//  LOCK_MAX   16  max consecutive locked grants before forced release (RAM_ARB_LOCK_EN only)
// PORTS
//  clk              in   1         system clock; the only clock
//  reset            in   1         synchronous, active-high reset
//  reset_req        in   1         reset-request; while high, no transfer is issued
//  mN_address       in   ADDR_W    master N word address (N = 0, 1)
//  mN_byteenable    in   DATA_W/8  master N byte lanes
//  mN_read          in   1         master N read request
//  mN_write         in   1         master N write request
//  mN_writedata     in   DATA_W    master N write data
//  mN_lock          in   1         master N lock request (RAM_ARB_LOCK_EN only)
//  mN_waitrequest   out  1         high = request of master N not accepted this cycle
//  mN_readdata      out  DATA_W    read data; valid only when mN_readdatavalid is high
//  mN_readdatavalid out  1         one-cycle pulse, exactly one per accepted read
//  ram_address      out  ADDR_W    RAM address
//  ram_byteenable   out  DATA_W/8  RAM byte enables
//  ram_chipselect   out  1         RAM select (high only on the issue cycle)
//  ram_write        out  1         RAM write strobe
//  ram_writedata    out  DATA_W    RAM write data
//  ram_clken        out  1         RAM clock enable; constant 1
//  ram_readdata     in   DATA_W    RAM q, valid one cycle after the issue cycle
// BEHAVIOUR
//  - Reset values: rr_ptr=0 (m0 preferred), rd_pend=0, state=ARB_IDLE, all readdatavalid=0.
//    mN_waitrequest is combinational and reads 1 while reset is high. readdata = ram_readdata.
//  - Request: reqN = mN_read | mN_write. mN_read & mN_write together is illegal; write wins
//    (asserted error in simulation).
//  - Grant (combinational, same cycle): with both requesting, grant goes to rr_ptr.
//    With one requesting, grant goes to that master. The winner sees waitrequest=0.
//    The loser and all idle masters see waitrequest=1.
//  - Issue cycle: ram_chipselect=1; ram_* copies the winner's fields.
//    Without a grant, ram_chipselect=0, ram_write=0 and the address/data/byteenable hold.
//  - After any accepted transfer, rr_ptr <= ~winner. Back-to-back transfers from
//    alternating masters are allowed every cycle.
//  - Read latency is 1. A read accepted in cycle N gives readdatavalid to the owner in
//    cycle N+1. The owner is recorded in the rd_own register. A new read may be accepted
//    in cycle N+1.
//  - Write latency is 0: done when waitrequest=0. A read in cycle N+1 of the same address
//    returns the new data.
//  - reset_req=1: all waitrequest=1 and chipselect=0. A read accepted in the previous cycle
//    still delivers readdatavalid. rr_ptr holds.
//  - reset mid-read: the pending readdatavalid is dropped; there is no pulse after reset.
//  - Address wrap is not applicable: masters present word addresses within depth.
//    Upper bits beyond ADDR_W are not present.
// CONFIGURATION
//  RAM_ARB_LOCK_EN defined:
//    - FSM ARB_IDLE -> ARB_LOCK0/ARB_LOCK1 when the winner is accepted with mN_lock=1.
//    - In ARB_LOCKn only master n is granted, and the other master waits.
//    - LOCKn -> IDLE when master n has a transfer accepted with mN_lock=0, or when lock_cnt
//      reaches LOCK_MAX accepted transfers. The forced release sets rr_ptr to the other
//      master.
//    - An idle locked owner keeps the lock (no timeout on idle cycles).
//  RAM_ARB_LOCK_EN not defined: mN_lock ports are absent, the FSM is ARB_IDLE only, and
//    arbitration is pure round-robin.
// STRUCTURE
//  Package cpu_nios_ram_pkg: ADDR_W/DATA_W defaults, arb_state_t enum
//  {ARB_IDLE, ARB_LOCK0, ARB_LOCK1}, master-id typedef.
//  Sub-module cpu_nios_rr_grant2: 2-way round-robin grant (req[1:0], ptr -> gnt[1:0]);
//  the rest is flat.
// TESTING
//  1. Reset, then m0 writes 0xDEADBEEF to 0x0010 (be=0xF) and reads 0x0010:
//     m0_waitrequest=0 both cycles; m0_readdatavalid one cycle later with 0xDEADBEEF.
//  2. Both masters read every cycle for 8 cycles: grants alternate m0,m1,m0,...
//     Each gets 4 readdatavalid pulses with its own data and none on the other master.
//  3. m1 writes be=0x3 data 0x0000ABCD over 0xFFFFFFFF at 0x7FFF, then reads it back:
//     reads 0xFFFFABCD (last address, partial byte enable).
//  4. reset_req high for 3 cycles with both requesting: zero chipselects, all waitrequest=1.
//     An in-flight read still returns. Grant resumes at rr_ptr afterwards.
//  5. Reset asserted the cycle after a read accept: no readdatavalid after reset,
//     and m0 has priority.
//  6. (RAM_ARB_LOCK_EN) m1 issues 20 locked reads while m0 requests: m0 is granted
//     exactly after the 16th m1 transfer; an unlocked m1 transfer releases earlier.

Source files
------------

// File: rtl/cpu_nios_ram_pkg.sv
// Shared types and default sizes for the Nios on-chip RAM arbiter.
// Holds the arbiter FSM state encoding and the master-id type used throughout.
package cpu_nios_ram_pkg;

  localparam int RAM_ADDR_W   = 15;
  localparam int RAM_DATA_W   = 32;
  localparam int RAM_LOCK_MAX = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t MID_M0 = 1'b0;
  localparam master_id_t MID_M1 = 1'b1;

endpackage

// File: rtl/cpu_nios_ram_arbiter_if.sv
// Avalon-MM master-side bus for one requester of the shared RAM.
// The lock signal exists only when RAM_ARB_LOCK_EN is defined.
interface cpu_nios_ram_arbiter_if
  import cpu_nios_ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  // Handshake: a transfer is accepted in any cycle where (read | write) is high
  // and waitrequest is low; until then the master holds address, byteenable,
  // writedata and the command. Each accepted read returns exactly one
  // readdatavalid pulse one cycle later; readdata is meaningful only then.
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
`ifdef RAM_ARB_LOCK_EN
  logic                lock;
`endif
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

`ifdef RAM_ARB_LOCK_EN
  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
`else
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
`endif

endinterface

// File: rtl/cpu_nios_rr_grant2.sv
// Two-way round-robin grant: a lone requester always wins, and on contention
// the master named by ptr_i wins.
module cpu_nios_rr_grant2
  import cpu_nios_ram_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_id_t ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (ptr_i == MID_M1) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/cpu_nios_ram_arbiter.sv
// Round-robin arbiter sharing the single-port on-chip RAM between the Nios data
// master (m0) and the alarm/DMA engine (m1). Define RAM_ARB_LOCK_EN for bus locking.
module cpu_nios_ram_arbiter
  import cpu_nios_ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
`ifdef RAM_ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = RAM_LOCK_MAX
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  cpu_nios_ram_arbiter_if.slave m0,
  cpu_nios_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output arb_state_t          state_o
);

  logic [1:0]          req;
  logic [1:0]          req_elig;
  logic [1:0]          gnt_raw;
  logic [1:0]          gnt;
  logic                blocked;
  logic                accept;
  master_id_t          winner;
  logic                win_write;

  master_id_t          rr_ptr_q, rr_ptr_d;
  logic                rd_pend_q, rd_pend_d;
  master_id_t          rd_own_q, rd_own_d;
  arb_state_t          state_q, state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W/8-1:0] be_q;
  logic [DATA_W-1:0]   wdata_q;

  assign req     = {m1.read | m1.write, m0.read | m0.write};
  assign blocked = reset | reset_req;

`ifdef RAM_ARB_LOCK_EN
  // While a master holds the lock the other one is simply not eligible.
  assign req_elig = {req[1] & (state_q != ARB_LOCK0),
                     req[0] & (state_q != ARB_LOCK1)};
`else
  assign req_elig = req;
`endif

  cpu_nios_rr_grant2 u_grant (
    .req_i (req_elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_raw)
  );

  assign gnt       = blocked ? 2'b00 : gnt_raw;
  assign accept    = |gnt;
  assign winner    = gnt[1] ? MID_M1 : MID_M0;
  assign win_write = (winner == MID_M1) ? m1.write : m0.write;

  assign m0.waitrequest = ~gnt[0];
  assign m1.waitrequest = ~gnt[1];

  // The RAM q port feeds both masters; readdatavalid tells each whose it is.
  assign m0.readdata      = ram_readdata;
  assign m1.readdata      = ram_readdata;
  assign m0.readdatavalid = rd_pend_q & (rd_own_q == MID_M0) & ~reset;
  assign m1.readdatavalid = rd_pend_q & (rd_own_q == MID_M1) & ~reset;

  assign ram_clken = 1'b1;
  assign state_o   = state_q;

  // Idle cycles keep the last address/data on the RAM pins to avoid toggling.
  always_comb begin
    ram_chipselect = accept;
    ram_write      = 1'b0;
    ram_address    = addr_q;
    ram_byteenable = be_q;
    ram_writedata  = wdata_q;
    if (accept) begin
      ram_write = win_write;
      if (winner == MID_M1) begin
        ram_address    = m1.address;
        ram_byteenable = m1.byteenable;
        ram_writedata  = m1.writedata;
      end else begin
        ram_address    = m0.address;
        ram_byteenable = m0.byteenable;
        ram_writedata  = m0.writedata;
      end
    end
  end

  always_comb begin
    rr_ptr_d  = accept ? ~winner : rr_ptr_q;
    rd_pend_d = accept & ~win_write;
    rd_own_d  = accept ? winner : rd_own_q;
  end

`ifdef RAM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             win_lock;

  assign win_lock = (winner == MID_M1) ? m1.lock : m0.lock;

  // lock_cnt counts accepted transfers of the owner, including the one that took the lock.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept && win_lock && (LOCK_MAX > 1)) begin
          state_d    = (winner == MID_M1) ? ARB_LOCK1 : ARB_LOCK0;
          lock_cnt_d = CNT_W'(1);
        end
      end
      ARB_LOCK0, ARB_LOCK1: begin
        if (accept) begin
          if (!win_lock || (int'(lock_cnt_q) + 1 >= LOCK_MAX)) begin
            state_d    = ARB_IDLE;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) lock_cnt_q <= '0;
    else       lock_cnt_q <= lock_cnt_d;
  end
`else
  always_comb begin
    state_d = ARB_IDLE;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= MID_M0;
      rd_pend_q <= 1'b0;
      rd_own_q  <= MID_M0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
      addr_q    <= ram_address;
      be_q      <= ram_byteenable;
      wdata_q   <= ram_writedata;
    end
  end

  // Read and write together is a master bug; the write is what gets issued.
  a_m0_rw_excl: assert property (@(posedge clk) disable iff (reset) !(m0.read && m0.write));
  a_m1_rw_excl: assert property (@(posedge clk) disable iff (reset) !(m1.read && m1.write));

endmodule
